// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection,
// stall/flush handling and a saturating count of inserted bubbles.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [7:0]      id_ctrl,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [3:0]      id_funct,
    input  logic            stall_in,
    input  logic            flush,
    output logic            ex_valid,
    output logic [7:0]      ex_ctrl,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [3:0]      ex_funct,
    output logic            pc_write,
    output logic            ifid_write,
    output logic [15:0]     bubble_count
);
    typedef struct packed {
        logic            valid;
        logic [7:0]      ctrl;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      funct;
    } ex_t;

    ex_t         ex_q, ex_d, id_in;
    logic        flush_pend_q, flush_pend_d;
    logic [15:0] bubble_count_q, bubble_count_d;
    logic        lu, eff_flush, bubble;

    // ctrl[6] is memRead: a load in EX whose rd feeds the ID instruction
    assign lu = ex_q.valid & ex_q.ctrl[6] & id_valid & (ex_q.rd != 5'd0)
              & (ex_q.rd == id_rs1 | ex_q.rd == id_rs2);
    assign pc_write   = ~(lu | stall_in | reset);
    assign ifid_write = pc_write;
    assign eff_flush  = (flush | flush_pend_q) & ~stall_in;
    assign bubble     = ~stall_in & (eff_flush | lu);
    assign id_in = {id_valid, id_valid ? id_ctrl : 8'h00, id_pc, id_rs1_data,
                    id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, id_funct};

    always_comb begin
        ex_d           = stall_in ? ex_q : bubble ? '0 : id_in;
        flush_pend_d   = stall_in & (flush_pend_q | flush);
        bubble_count_d = (bubble && bubble_count_q != 16'hFFFF) ? bubble_count_q + 16'd1
                                                                 : bubble_count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q           <= '0;
            flush_pend_q   <= 1'b0;
            bubble_count_q <= 16'h0000;
        end else begin
            ex_q           <= ex_d;
            flush_pend_q   <= flush_pend_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_ctrl      = ex_q.ctrl;
    assign ex_pc        = ex_q.pc;
    assign ex_rs1_data  = ex_q.rs1_data;
    assign ex_rs2_data  = ex_q.rs2_data;
    assign ex_imm       = ex_q.imm;
    assign ex_rs1       = ex_q.rs1;
    assign ex_rs2       = ex_q.rs2;
    assign ex_rd        = ex_q.rd;
    assign ex_funct     = ex_q.funct;
    assign bubble_count = bubble_count_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scoreboard bench for the ID/EX stage register.
module tb_id_ex_stage;
    typedef struct packed {
        logic        valid;
        logic [7:0]  ctrl;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  funct;
        logic [15:0] bc;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset, id_valid, stall_in, flush;
    logic [7:0]  id_ctrl;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_funct;
    logic        ex_valid, pc_write, ifid_write;
    logic [7:0]  ex_ctrl;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_funct;
    logic [15:0] bubble_count;

    rec_t        sb[$];
    rec_t        last;
    logic [15:0] bc_exp;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
        .stall_in(stall_in), .flush(flush), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
        .pc_write(pc_write), .ifid_write(ifid_write), .bubble_count(bubble_count)
    );

    task automatic chk(input string tag, input logic [171:0] obs, input logic [171:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [7:0] c, input logic [31:0] pc,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                          input logic [3:0] f);
        id_valid = v; id_ctrl = c; id_pc = pc; id_rs1_data = a; id_rs2_data = b;
        id_imm = imm; id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_funct = f;
    endtask

    task automatic push_load();
        last = {id_valid, id_valid ? id_ctrl : 8'h00, id_pc, id_rs1_data, id_rs2_data,
                id_imm, id_rs1, id_rs2, id_rd, id_funct, bc_exp};
        sb.push_back(last);
    endtask

    task automatic push_bubble();
        if (bc_exp != 16'hFFFF) bc_exp = bc_exp + 16'd1;
        last = '0;
        last.bc = bc_exp;
        sb.push_back(last);
    endtask

    task automatic push_reset();
        bc_exp = 16'h0000;
        last = '0;
        sb.push_back(last);
    endtask

    task automatic tick(input string tag);
        rec_t e;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(tag, {ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
                  ex_rs1, ex_rs2, ex_rd, ex_funct, bubble_count}, e);
    endtask

    task automatic chk_pcw(input string tag, input logic exp);
        #1;
        chk(tag, 172'({pc_write, ifid_write}), 172'({exp, exp}));
    endtask

    initial begin
        bc_exp = 16'h0000;
        reset = 1'b1; stall_in = 1'b0; flush = 1'b0;
        set_id(1, 8'hFF, 32'hDEAD, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 4'hF);
        chk_pcw("pcw_in_reset", 1'b0);
        push_reset(); tick("reset_a");
        push_reset(); tick("reset_b");
        reset = 1'b0;
        // basic load
        set_id(1, 8'h06, 32'h100, 32'hAA, 32'hBB, 32'h10, 5'd1, 5'd2, 5'd5, 4'h3);
        chk_pcw("pcw_idle", 1'b1);
        push_load(); tick("basic_load");
        // load into EX, then dependent consumer on rs2
        set_id(1, 8'h68, 32'h104, 32'h11, 32'h22, 32'h4, 5'd1, 5'd0, 5'd3, 4'h2);
        chk_pcw("pcw_no_lu_alu", 1'b1);
        push_load(); tick("lw_load");
        set_id(1, 8'h06, 32'h108, 32'h33, 32'h44, 32'h8, 5'd7, 5'd3, 5'd8, 4'h0);
        chk_pcw("pcw_lu", 1'b0);
        push_bubble(); tick("lu_bubble");
        chk_pcw("pcw_after_lu", 1'b1);
        push_load(); tick("lu_consumer_load");
        // x0 exemption
        set_id(1, 8'h68, 32'h10C, 32'h55, 32'h66, 32'hC, 5'd2, 5'd2, 5'd0, 4'h2);
        push_load(); tick("lw_x0_load");
        set_id(1, 8'h06, 32'h110, 32'h77, 32'h88, 32'h0, 5'd0, 5'd5, 5'd9, 4'h8);
        chk_pcw("pcw_x0", 1'b1);
        push_load(); tick("x0_no_stall");
        // invalid ID: ctrl zeroed, and no hazard from an invalid consumer
        set_id(1, 8'h68, 32'h114, 32'h1, 32'h2, 32'h3, 5'd1, 5'd1, 5'd4, 4'h2);
        push_load(); tick("lw_rd4_load");
        set_id(0, 8'h33, 32'h118, 32'h9, 32'hA, 32'hB, 5'd4, 5'd4, 5'd6, 4'h5);
        chk_pcw("pcw_invalid_id", 1'b1);
        push_load(); tick("invalid_ctrl_zero");
        // flush during stall
        set_id(1, 8'h06, 32'h200, 32'hC1, 32'hC2, 32'h20, 5'd10, 5'd11, 5'd12, 4'h1);
        push_load(); tick("pre_stall_load");
        set_id(1, 8'h22, 32'h204, 32'hD1, 32'hD2, 32'h24, 5'd13, 5'd14, 5'd15, 4'h6);
        stall_in = 1'b1; flush = 1'b1;
        chk_pcw("pcw_stall", 1'b0);
        push_load_hold(); tick("stall_hold_1");
        flush = 1'b0;
        push_load_hold(); tick("stall_hold_2");
        push_load_hold(); tick("stall_hold_3");
        stall_in = 1'b0;
        chk_pcw("pcw_after_stall", 1'b1);
        push_bubble(); tick("pending_flush_bubble");
        push_load(); tick("post_flush_load");
        // flush together with load-use is a single bubble
        set_id(1, 8'h68, 32'h300, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd20, 4'h2);
        push_load(); tick("lw_rd20_load");
        set_id(1, 8'h06, 32'h304, 32'h4, 32'h5, 32'h6, 5'd20, 5'd2, 5'd21, 4'h0);
        flush = 1'b1;
        chk_pcw("pcw_flush_lu", 1'b0);
        push_bubble(); tick("flush_lu_bubble");
        flush = 1'b0;
        push_load(); tick("after_flush_lu_load");
        // reset mid-stall discards the pending flush
        stall_in = 1'b1; flush = 1'b1;
        push_load_hold(); tick("stall_before_reset");
        reset = 1'b1;
        push_reset(); tick("reset_mid_stall");
        reset = 1'b0; stall_in = 1'b0; flush = 1'b0;
        push_load(); tick("load_after_reset");
        // saturation: 65536 flush bubbles in total
        flush = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", 172'(bubble_count), 172'(16'hFFFE));
        bc_exp = 16'hFFFE;
        push_bubble(); tick("sat_ffff");
        push_bubble(); tick("sat_no_wrap");
        reset = 1'b1;
        chk_pcw("pcw_final_reset", 1'b0);
        push_reset(); tick("final_reset");
        reset = 1'b0; flush = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    task automatic push_load_hold();
        sb.push_back(last);
    endtask
endmodule
